loader_write_bridge: RTL and testbench

LOADER_WRITE_BRIDGE -- requirements
Module: loader_write_bridge

---
 rtl/loader_pkg.sv | 15 +
 rtl/loader_fifo.sv | 58 +++++
 rtl/loader_write_bridge.sv | 139 +++++++++++++
 tb/tb_loader_write_bridge.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/loader_pkg.sv
// Shared FSM states and default sizing for the game-loader SDRAM write bridge.
// Imported by the bridge top and its FIFO.
package loader_pkg;

    localparam int unsigned LOADER_DEPTH  = 8;
    localparam int unsigned LOADER_ADDR_W = 22;

    typedef enum logic [1:0] {
        IDLE,
        LOADING,
        DRAIN,
        DONE
    } state_e;

endpackage

// File: rtl/loader_fifo.sv
// Synchronous FIFO with registered pointers and occupancy; head is read straight from storage.
// Caller only asserts push_i/pop_i when legal (pop when non-empty, push when not full or popping).
module loader_fifo
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH = LOADER_DEPTH,
    parameter int unsigned W     = LOADER_ADDR_W + 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] wdata_i,
    output logic [W-1:0] rdata_o,
    output logic         full_o,
    output logic         empty_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam logic [PW:0] FULL_CNT = (PW + 1)'(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [PW:0]   count_q;

    // Storage is not reset; pointers and occupancy define what is valid.
    always_ff @(posedge clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/loader_write_bridge.sv
// Buffers game-loader bytes and writes one per SDRAM slot; mem_write rises one edge after the next slot.
// A full FIFO drops bytes and sets sticky overflow; LOADER_BRIDGE_CHECKSUM_EN adds a running byte checksum.
module loader_write_bridge
    import loader_pkg::*;
#(
    parameter int unsigned DEPTH  = LOADER_DEPTH,
    parameter int unsigned ADDR_W = LOADER_ADDR_W
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [ADDR_W-1:0] in_addr,
    input  logic [7:0]        in_data,
    input  logic              loader_done,
    input  logic              slot,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic              mem_write,
    output logic              busy,
    output logic              overflow,
`ifdef LOADER_BRIDGE_CHECKSUM_EN
    output logic [15:0]       checksum,
`endif
    output logic              done
);

    localparam int unsigned EW = ADDR_W + 8;

    state_e              state_q;
    logic                done_q;
    logic                mem_write_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [7:0]          mem_data_q;
    logic                overflow_q;

    logic                fifo_full;
    logic                fifo_empty;
    logic [EW-1:0]       head;
    logic                accepting;
    logic                pop;
    logic                push;
    logic                drop;

    // A pop frees the head slot this cycle, so a full FIFO can still take a byte.
    assign accepting = (state_q != DONE);
    assign pop       = slot & ~fifo_empty;
    assign push      = in_valid & accepting & (~fifo_full | pop);
    assign drop      = in_valid & accepting & fifo_full & ~pop;

    loader_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i ({in_addr, in_data}),
        .rdata_o (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            overflow_q  <= 1'b0;
        end else begin
            if (slot) begin
                mem_write_q <= ~fifo_empty;
                if (!fifo_empty) begin
                    {mem_addr_q, mem_data_q} <= head;
                end
            end
            if (drop) begin
                overflow_q <= 1'b1;
            end
        end
    end

    // A byte arriving on the finishing slot keeps the bridge in DRAIN so it is not lost.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= IDLE;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (push) begin
                        state_q <= LOADING;
                    end else if (loader_done) begin
                        state_q <= DRAIN;
                    end
                end
                LOADING: begin
                    if (loader_done) begin
                        state_q <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (slot && fifo_empty && !push) begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= DONE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

`ifdef LOADER_BRIDGE_CHECKSUM_EN
    logic [15:0] checksum_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            checksum_q <= '0;
        end else if (pop && state_q != DONE) begin
            checksum_q <= checksum_q + {8'h00, head[7:0]};
        end
    end

    assign checksum = checksum_q;
`endif

    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign overflow  = overflow_q;
    assign done      = done_q;
    assign busy      = ~fifo_empty | mem_write_q;

endmodule

// File: tb/tb_loader_write_bridge.sv
// Table-driven and scripted checks of loader_write_bridge with a write-order scoreboard.
module tb_loader_write_bridge;

    localparam int AW = 22;

    logic          clock = 1'b0;
    logic          reset;
    logic          in_valid;
    logic [AW-1:0] in_addr;
    logic [7:0]    in_data;
    logic          loader_done;
    logic          slot;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_data;
    logic          mem_write;
    logic          busy;
    logic          overflow;
    logic          done;
`ifdef LOADER_BRIDGE_CHECKSUM_EN
    logic [15:0]   checksum;
`endif

    always #5 clock = ~clock;

    loader_write_bridge #(
        .DEPTH  (8),
        .ADDR_W (AW)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_addr     (in_addr),
        .in_data     (in_data),
        .loader_done (loader_done),
        .slot        (slot),
        .mem_addr    (mem_addr),
        .mem_data    (mem_data),
        .mem_write   (mem_write),
        .busy        (busy),
        .overflow    (overflow),
`ifdef LOADER_BRIDGE_CHECKSUM_EN
        .checksum    (checksum),
`endif
        .done        (done)
    );

    typedef struct {
        int rst, iv, a, d, sl, ld, acc;
        int mw, ea, ed, bsy, ovf, dn;
    } vec_t;

    vec_t        tbl [23];
    logic [29:0] exp_q [$];
    int          pass_cnt = 0;
    int          total_cnt = 0;
    int          wr_seen = 0;
    int          mw_cycles = 0;
    int          phase = 0;
    bit          slot_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    endtask

    // One clock with the given slot value; afterwards outputs reflect that edge.
    task automatic step(input logic s);
        logic [29:0] e;
        slot = s;
        @(posedge clock);
        #1;
        if (mem_write === 1'b1) mw_cycles++;
        if (!reset && s && mem_write === 1'b1) begin
            wr_seen++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL sb_unexpected_write: got write 0x%0h/0x%0h, required none", mem_addr, mem_data);
            end else begin
                e = exp_q.pop_front();
                check("sb_addr", 32'(mem_addr), 32'(e[29:8]));
                check("sb_data", 32'(mem_data), 32'(e[7:0]));
            end
        end
    endtask

    task automatic cyc();
        logic s;
        s = slot_on && (phase == 0);
        phase = (phase + 1) % 4;
        step(s);
    endtask

    task automatic push_byte(input logic [21:0] a, input logic [7:0] d, input bit acc);
        in_valid = 1'b1;
        in_addr  = a;
        in_data  = d;
        if (acc) exp_q.push_back({a, d});
        cyc();
        in_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        in_valid    = 1'b0;
        loader_done = 1'b0;
        step(1'b0);
        reset = 1'b0;
        exp_q.delete();
        wr_seen   = 0;
        mw_cycles = 0;
        phase     = 0;
    endtask

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_addr = '0; in_data = '0;
        loader_done = 1'b0; slot = 1'b0;

        //        rst iv a      d     sl ld acc  mw ea     ed    bsy ovf dn
        tbl[0]  = '{1, 0, 'h0,   'h0,  0, 0, 0,   0, 'h0,   'h0,  0, 0, 0};
        tbl[1]  = '{0, 1, 'h10,  'hA5, 0, 0, 1,   0, 'h0,   'h0,  1, 0, 0};
        tbl[2]  = '{0, 0, 'h0,   'h0,  0, 0, 0,   0, 'h0,   'h0,  1, 0, 0};
        tbl[3]  = '{0, 0, 'h0,   'h0,  1, 0, 0,   1, 'h10,  'hA5, 1, 0, 0};
        tbl[4]  = '{0, 0, 'h0,   'h0,  0, 0, 0,   1, 'h10,  'hA5, 1, 0, 0};
        tbl[5]  = '{0, 0, 'h0,   'h0,  0, 0, 0,   1, 'h10,  'hA5, 1, 0, 0};
        tbl[6]  = '{0, 0, 'h0,   'h0,  0, 0, 0,   1, 'h10,  'hA5, 1, 0, 0};
        tbl[7]  = '{0, 0, 'h0,   'h0,  1, 0, 0,   0, 'h10,  'hA5, 0, 0, 0};
        tbl[8]  = '{0, 0, 'h0,   'h0,  0, 0, 0,   0, 'h10,  'hA5, 0, 0, 0};
        tbl[9]  = '{0, 1, 'h123, 'h3C, 1, 0, 1,   0, 'h10,  'hA5, 1, 0, 0};
        tbl[10] = '{0, 0, 'h0,   'h0,  0, 0, 0,   0, 'h10,  'hA5, 1, 0, 0};
        tbl[11] = '{0, 0, 'h0,   'h0,  0, 0, 0,   0, 'h10,  'hA5, 1, 0, 0};
        tbl[12] = '{0, 0, 'h0,   'h0,  0, 0, 0,   0, 'h10,  'hA5, 1, 0, 0};
        tbl[13] = '{0, 0, 'h0,   'h0,  1, 0, 0,   1, 'h123, 'h3C, 1, 0, 0};
        tbl[14] = '{0, 0, 'h0,   'h0,  0, 0, 0,   1, 'h123, 'h3C, 1, 0, 0};
        tbl[15] = '{0, 0, 'h0,   'h0,  0, 0, 0,   1, 'h123, 'h3C, 1, 0, 0};
        tbl[16] = '{0, 0, 'h0,   'h0,  0, 0, 0,   1, 'h123, 'h3C, 1, 0, 0};
        tbl[17] = '{0, 0, 'h0,   'h0,  1, 0, 0,   0, 'h123, 'h3C, 0, 0, 0};
        tbl[18] = '{0, 0, 'h0,   'h0,  0, 1, 0,   0, 'h123, 'h3C, 0, 0, 0};
        tbl[19] = '{0, 0, 'h0,   'h0,  0, 1, 0,   0, 'h123, 'h3C, 0, 0, 0};
        tbl[20] = '{0, 0, 'h0,   'h0,  1, 1, 0,   0, 'h123, 'h3C, 0, 0, 1};
        tbl[21] = '{0, 1, 'h55,  'h77, 0, 1, 0,   0, 'h123, 'h3C, 0, 0, 1};
        tbl[22] = '{0, 0, 'h0,   'h0,  1, 1, 0,   0, 'h123, 'h3C, 0, 0, 1};

        for (int i = 0; i < 23; i++) begin
            reset       = (tbl[i].rst != 0);
            in_valid    = (tbl[i].iv != 0);
            in_addr     = tbl[i].a[21:0];
            in_data     = tbl[i].d[7:0];
            loader_done = (tbl[i].ld != 0);
            if (tbl[i].rst != 0) exp_q.delete();
            if (tbl[i].acc != 0) exp_q.push_back({tbl[i].a[21:0], tbl[i].d[7:0]});
            step(tbl[i].sl != 0);
            check($sformatf("v%0d_mem_write", i), 32'(mem_write), tbl[i].mw);
            check($sformatf("v%0d_mem_addr", i), 32'(mem_addr), tbl[i].ea);
            check($sformatf("v%0d_mem_data", i), 32'(mem_data), tbl[i].ed);
            check($sformatf("v%0d_busy", i), 32'(busy), tbl[i].bsy);
            check($sformatf("v%0d_overflow", i), 32'(overflow), tbl[i].ovf);
            check($sformatf("v%0d_done", i), 32'(done), tbl[i].dn);
        end
        reset = 1'b0; in_valid = 1'b0; loader_done = 1'b0;
        check("tbl_sb_empty", 32'(exp_q.size()), 32'd0);

        // Eight back-to-back bytes with slots running.
        do_reset();
`ifdef LOADER_BRIDGE_CHECKSUM_EN
        check("cks_reset", 32'(checksum), 32'h0);
`endif
        slot_on = 1'b1;
        for (int i = 0; i < 8; i++) push_byte(22'(22'h100 + i), 8'(8'h10 + 3 * i), 1'b1);
        repeat (40) cyc();
        check("b2b_writes", 32'(wr_seen), 32'd8);
        check("b2b_mw_cycles", 32'(mw_cycles), 32'd32);
        check("b2b_overflow", 32'(overflow), 32'd0);
        check("b2b_sb_empty", 32'(exp_q.size()), 32'd0);

        // Nine bytes with no slots: ninth dropped.
        do_reset();
        slot_on = 1'b0;
        for (int i = 0; i < 9; i++) push_byte(22'(22'h2000 + i), 8'(8'hC0 + i), i < 8);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_busy", 32'(busy), 32'd1);
        check("ovf_no_write", 32'(mem_write), 32'd0);
        slot_on = 1'b1;
        repeat (44) cyc();
        check("ovf_writes", 32'(wr_seen), 32'd8);
        check("ovf_sb_empty", 32'(exp_q.size()), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);

        // Full FIFO: push and slot in the same cycle.
        do_reset();
        slot_on = 1'b0;
        for (int i = 0; i < 8; i++) push_byte(22'(22'h3100 + i), 8'(8'h40 + i), 1'b1);
        in_valid = 1'b1; in_addr = 22'h2AA; in_data = 8'h5A;
        exp_q.push_back({22'h2AA, 8'h5A});
        step(1'b1);
        in_valid = 1'b0;
        check("full_pp_overflow", 32'(overflow), 32'd0);
        check("full_pp_write", 32'(mem_write), 32'd1);
        push_byte(22'h2BB, 8'h6B, 1'b0);
        check("full_pp_still_full", 32'(overflow), 32'd1);
        slot_on = 1'b1; phase = 0;
        repeat (40) cyc();
        check("full_pp_writes", 32'(wr_seen), 32'd9);
        check("full_pp_sb_empty", 32'(exp_q.size()), 32'd0);

        // loader_done with three queued bytes.
        do_reset();
        slot_on = 1'b0;
        push_byte(22'h3000, 8'h01, 1'b1);
        push_byte(22'h3001, 8'h02, 1'b1);
        push_byte(22'h3002, 8'hFF, 1'b1);
        loader_done = 1'b1;
        step(1'b0);
        check("drain_done_early", 32'(done), 32'd0);
        for (int k = 1; k <= 4; k++) begin
            repeat (3) step(1'b0);
            step(1'b1);
            if (k < 4) begin
                check($sformatf("drain_s%0d_done", k), 32'(done), 32'd0);
                check($sformatf("drain_s%0d_mw", k), 32'(mem_write), 32'd1);
            end else begin
                check("drain_done", 32'(done), 32'd1);
                check("drain_mw_off", 32'(mem_write), 32'd0);
                check("drain_busy", 32'(busy), 32'd0);
            end
        end
`ifdef LOADER_BRIDGE_CHECKSUM_EN
        check("cks_value", 32'(checksum), 32'h0102);
`endif
        loader_done = 1'b0;
        repeat (5) step(1'b0);
        check("done_held", 32'(done), 32'd1);

        // Reset during an in-flight write with five bytes queued.
        do_reset();
        slot_on = 1'b0;
        for (int i = 0; i < 6; i++) push_byte(22'(22'h4000 + i), 8'(8'h90 + i), 1'b1);
        step(1'b1);
        check("rst_pre_mw", 32'(mem_write), 32'd1);
        reset = 1'b1; in_valid = 1'b1; in_addr = 22'h3FFFFF; in_data = 8'hEE;
        step(1'b1);
        check("rst_mw", 32'(mem_write), 32'd0);
        check("rst_addr", 32'(mem_addr), 32'd0);
        check("rst_data", 32'(mem_data), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_ovf", 32'(overflow), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        reset = 1'b0; in_valid = 1'b0;
        exp_q.delete();
        wr_seen = 0;
        slot_on = 1'b1; phase = 0;
        repeat (40) cyc();
        check("rst_no_writes", 32'(wr_seen), 32'd0);
        check("rst_idle_busy", 32'(busy), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
